// File: rtl/activity_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : activity_matrix                                              |
// | Description : MIDI in/out activity LED matrix scanned through a 74HC595     |
// |               chain, with per-LED pulse stretching over whole scan frames.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module activity_matrix #(
    parameter int CHANNELS       = 16,
    parameter int COLS           = 8,
    parameter int SR_BITS        = 16,
    parameter int CLKDIV         = 128,
    parameter int HOLD           = 3,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] out,
    output logic                sck,
    output logic                rck,
    output logic                ser
);

    localparam int c_ROWS = 2 * CHANNELS / COLS;
    localparam int c_LEDS = 2 * CHANNELS;
    localparam int c_HW   = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam int c_DW   = $clog2(CLKDIV);
    localparam int c_CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_BW   = (SR_BITS > 1) ? $clog2(SR_BITS) : 1;

    localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(CLKDIV - 1);
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(COLS - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(SR_BITS - 1);
    localparam logic [c_HW-1:0] c_HOLD_LD  = c_HW'(HOLD);

    typedef enum logic [1:0] {
        S_LOAD     = 2'd0,
        S_SHIFT_LO = 2'd1,
        S_SHIFT_HI = 2'd2,
        S_LATCH    = 2'd3
    } state_t;

    state_t                          r_state_q, w_state_d;
    logic [c_DW-1:0]                 r_div_q, w_div_d;
    logic [c_CW-1:0]                 r_col_q, w_col_d, w_col_next;
    logic [c_BW-1:0]                 r_bitcnt_q, w_bitcnt_d;
    logic [SR_BITS-1:0]              r_word_q, w_word_d, w_snap;
    logic                            r_sck_q, w_sck_d;
    logic                            r_rck_q, w_rck_d;
    logic                            r_ser_q, w_ser_d;
    logic [c_LEDS-1:0][c_HW-1:0]     r_hold_q, w_hold_d;
    logic [c_LEDS-1:0]               w_act, w_lit;
    logic                            w_tick, w_frame_end;

    // LED index: 0..CHANNELS-1 are receive ports, CHANNELS.. are transmit ports
    assign w_act      = {out, in};
    assign w_tick     = (r_div_q == c_DIV_LAST);
    assign w_div_d    = w_tick ? '0 : r_div_q + 1'b1;
    assign w_col_next = (r_col_q == c_COL_LAST) ? '0 : r_col_q + 1'b1;

    always_comb begin
        w_hold_d = r_hold_q;
        w_lit    = '0;
        for (int i = 0; i < c_LEDS; i++) begin
            w_lit[i] = w_act[i] | (r_hold_q[i] != '0);
            if (w_act[i]) begin
                w_hold_d[i] = c_HOLD_LD;
            end else if (w_frame_end && (r_hold_q[i] != '0)) begin
                w_hold_d[i] = r_hold_q[i] - 1'b1;
            end
        end
    end

    // Even rows carry receive activity, odd rows transmit, for the column about to be driven
    always_comb begin
        w_snap = '0;
        for (int c = 0; c < COLS; c++) begin
            w_snap[c] = (w_col_next == c_CW'(c)) ^ (COL_ACTIVE_LOW != 0);
            if (w_col_next == c_CW'(c)) begin
                for (int r = 0; r < c_ROWS; r++) begin
                    w_snap[COLS + r] = w_lit[(r % 2) * CHANNELS + (r / 2) * COLS + c];
                end
            end
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_col_d     = r_col_q;
        w_word_d    = r_word_q;
        w_bitcnt_d  = r_bitcnt_q;
        w_sck_d     = r_sck_q;
        w_rck_d     = r_rck_q;
        w_ser_d     = r_ser_q;
        w_frame_end = 1'b0;
        if (w_tick) begin
            case (r_state_q)
                S_LOAD: begin
                    w_col_d    = w_col_next;
                    w_word_d   = w_snap;
                    w_bitcnt_d = c_BIT_LAST;
                    w_sck_d    = 1'b0;
                    w_rck_d    = 1'b0;
                    w_ser_d    = w_snap[SR_BITS-1];
                    w_state_d  = S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    w_sck_d   = 1'b1;
                    w_state_d = S_SHIFT_HI;
                end
                S_SHIFT_HI: begin
                    w_sck_d = 1'b0;
                    if (r_bitcnt_q == '0) begin
                        w_rck_d   = 1'b1;
                        w_state_d = S_LATCH;
                    end else begin
                        // Next bit is presented on the falling edge, a full tick before the rise
                        w_bitcnt_d = r_bitcnt_q - 1'b1;
                        w_ser_d    = r_word_q[w_bitcnt_d];
                        w_state_d  = S_SHIFT_LO;
                    end
                end
                default: begin
                    w_sck_d     = 1'b0;
                    w_rck_d     = 1'b0;
                    w_frame_end = (r_col_q == c_COL_LAST);
                    w_state_d   = S_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_LOAD;
            r_div_q    <= '0;
            r_col_q    <= c_COL_LAST;
            r_word_q   <= '0;
            r_bitcnt_q <= '0;
            r_sck_q    <= 1'b0;
            r_rck_q    <= 1'b0;
            r_ser_q    <= 1'b0;
            r_hold_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_div_q    <= w_div_d;
            r_col_q    <= w_col_d;
            r_word_q   <= w_word_d;
            r_bitcnt_q <= w_bitcnt_d;
            r_sck_q    <= w_sck_d;
            r_rck_q    <= w_rck_d;
            r_ser_q    <= w_ser_d;
            r_hold_q   <= w_hold_d;
        end
    end

    assign sck = r_sck_q;
    assign rck = r_rck_q;
    assign ser = r_ser_q;

endmodule
`default_nettype wire

// File: tb/tb_activity_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_activity_matrix                                           |
// | Description : Self-checking bench for activity_matrix (active-high and     |
// |               active-low column variants side by side).                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_activity_matrix;

    localparam int CH    = 16;
    localparam int NCOL  = 8;
    localparam int SRB   = 16;
    localparam int DIV   = 4;
    localparam int HOLDV = 3;
    localparam int PER   = 2 * SRB + 2;   // ticks per column period

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_v = '0;
    logic [15:0] out_v = '0;
    logic        sck0, rck0, ser0, sck1, rck1, ser1;

    always #5 clk = ~clk;

    activity_matrix #(.CHANNELS(CH), .COLS(NCOL), .SR_BITS(SRB), .CLKDIV(DIV),
                      .HOLD(HOLDV), .COL_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .in(in_v), .out(out_v),
        .sck(sck0), .rck(rck0), .ser(ser0));

    activity_matrix #(.CHANNELS(CH), .COLS(NCOL), .SR_BITS(SRB), .CLKDIV(DIV),
                      .HOLD(HOLDV), .COL_ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .in(in_v), .out(out_v),
        .sck(sck1), .rck(rck1), .ser(ser1));

    int checks   = 0;
    int failures = 0;

    logic [15:0] pend[$], exp_q[$], got0[$], got1[$], wlog[$], alog[$];

    // Reference model: expected word at each column load, from tick timing and hold rules
    int          ecnt, fe_total, m_tn, m_col, m_idx;
    bit          ever[32];
    int          fe_at[32];
    logic [31:0] m_av;
    logic [15:0] m_e;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            ecnt = 0;
            fe_total = 0;
            pend.delete();
            for (int i = 0; i < 32; i++) begin
                ever[i] = 1'b0;
                fe_at[i] = 0;
            end
        end else begin
            m_av = {out_v, in_v};
            ecnt++;
            if (ecnt % DIV == 0) begin
                m_tn = ecnt / DIV;
                if ((m_tn - 1) % PER == 0) begin
                    m_col = ((m_tn - 1) / PER) % NCOL;
                    m_e = 16'(1) << m_col;
                    for (int r = 0; r < 2 * CH / NCOL; r++) begin
                        m_idx = (r % 2) * CH + (r / 2) * NCOL + m_col;
                        if (m_av[m_idx] || (ever[m_idx] && (fe_total - fe_at[m_idx]) < HOLDV))
                            m_e[NCOL + r] = 1'b1;
                    end
                    pend.push_back(m_e);
                end
                if (m_tn % (PER * NCOL) == 0) fe_total++;
            end
            for (int i = 0; i < 32; i++) begin
                if (m_av[i]) begin
                    ever[i] = 1'b1;
                    fe_at[i] = fe_total;
                end
            end
        end
    end

    // Serial-link monitor: rebuilds shifted words and records timing violations
    int          bits[2], hi_len[2], lo_len[2];
    logic [15:0] sr[2];
    logic        psck[2], prck[2], pser[2];
    logic        mon_s, mon_r, mon_d;
    int          ncnt = 0, last_rck = 0;
    bit          last_ok = 1'b0;
    int          ser_bad = 0, high_bad = 0, low_bad = 0, gap_bad = 0, bits_bad = 0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            psck[d] = 1'b0; prck[d] = 1'b0; pser[d] = 1'b0;
            bits[d] = 0; hi_len[d] = 0; lo_len[d] = 0; sr[d] = '0;
        end
        forever begin
            @(negedge clk);
            ncnt++;
            for (int d = 0; d < 2; d++) begin
                mon_s = (d == 0) ? sck0 : sck1;
                mon_r = (d == 0) ? rck0 : rck1;
                mon_d = (d == 0) ? ser0 : ser1;
                if (rst) begin
                    bits[d] = 0; sr[d] = '0; hi_len[d] = 0; lo_len[d] = 0;
                    if (d == 0) last_ok = 1'b0;
                end else begin
                    if (mon_s && !psck[d]) begin
                        if (mon_d !== pser[d]) ser_bad++;
                        if (bits[d] > 0 && lo_len[d] != DIV) low_bad++;
                        sr[d] = {sr[d][14:0], mon_d};
                        bits[d]++;
                        hi_len[d] = 1;
                    end else if (mon_s) begin
                        hi_len[d]++;
                    end
                    if (!mon_s && psck[d]) begin
                        if (hi_len[d] != DIV) high_bad++;
                        lo_len[d] = 1;
                    end else if (!mon_s) begin
                        lo_len[d]++;
                    end
                    if (mon_r && !prck[d]) begin
                        if (bits[d] != SRB) bits_bad++;
                        bits[d] = 0;
                        if (d == 0) begin
                            got0.push_back(sr[0]);
                            if (pend.size() > 0) exp_q.push_back(pend.pop_front());
                            else exp_q.push_back(16'hxxxx);
                            if (last_ok && (ncnt - last_rck) != PER * DIV) gap_bad++;
                            last_rck = ncnt;
                            last_ok = 1'b1;
                        end else begin
                            got1.push_back(sr[1]);
                        end
                    end
                end
                psck[d] = mon_s; prck[d] = mon_r; pser[d] = mon_d;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic flush(input string tag);
        logic [15:0] g0, g1, e;
        while (got0.size() > 0) begin
            g0 = got0.pop_front();
            e  = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            g1 = (got1.size() > 0) ? got1.pop_front() : 16'hxxxx;
            check({tag, "_word"}, {16'h0, g0}, {16'h0, e});
            check({tag, "_al_word"}, {16'h0, g1}, {16'h0, e ^ 16'h00FF});
            wlog.push_back(g0);
            alog.push_back(g1);
        end
    endtask

    task automatic wait_words(input int n, input string tag);
        int budget;
        budget = n * PER * DIV + 200;
        while (got0.size() < n && budget > 0) begin
            step();
            budget--;
        end
        check({tag, "_count"}, 32'(got0.size()), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_v = '0;
        out_v = '0;
        repeat (3) step();
        got0.delete(); got1.delete(); exp_q.delete(); wlog.delete(); alog.delete();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;

        // Reset state
        repeat (3) step();
        check("rst_sck", {31'h0, sck0}, 32'h0);
        check("rst_rck", {31'h0, rck0}, 32'h0);
        check("rst_ser", {31'h0, ser0}, 32'h0);
        check("rst_al_ser", {31'h0, ser1}, 32'h0);
        rst = 1'b0;

        // Column walk with no activity
        wait_words(9, "walk");
        flush("walk");
        check("walk_col0", {16'h0, wlog[0]}, 32'h0001);
        check("walk_col1", {16'h0, wlog[1]}, 32'h0002);
        check("walk_col7", {16'h0, wlog[7]}, 32'h0080);
        check("walk_wrap", {16'h0, wlog[8]}, 32'h0001);
        check("al_col0", {16'h0, alog[0]}, 32'h00FE);

        // Steady receive activity on port 9
        do_reset();
        in_v[9] = 1'b1;
        wait_words(3, "in9");
        flush("in9");
        check("in9_col0", {16'h0, wlog[0]}, 32'h0001);
        check("in9_col1", {16'h0, wlog[1]}, 32'h0402);

        // Single-clock transmit pulse stretched over three frames
        do_reset();
        step();
        out_v[0] = 1'b1;
        step();
        out_v[0] = 1'b0;
        wait_words(33, "pulse");
        flush("pulse");
        check("pulse_f0", {16'h0, wlog[0]}, 32'h0201);
        check("pulse_f1", {16'h0, wlog[8]}, 32'h0201);
        check("pulse_f2", {16'h0, wlog[16]}, 32'h0201);
        check("pulse_f3", {16'h0, wlog[24]}, 32'h0001);
        check("pulse_f4", {16'h0, wlog[32]}, 32'h0001);

        // Reset in the middle of a transfer
        do_reset();
        budget = 1000;
        while (bits[0] < 5 && budget > 0) begin
            step();
            budget--;
        end
        check("abort_bits", 32'(bits[0]), 32'd5);
        rst = 1'b1;
        repeat (3) step();
        check("abort_sck", {31'h0, sck0}, 32'h0);
        check("abort_rck", {31'h0, rck0}, 32'h0);
        check("abort_ser", {31'h0, ser0}, 32'h0);
        check("abort_no_latch", 32'(got0.size()), 32'd0);
        rst = 1'b0;
        wait_words(1, "abort");
        flush("abort");
        check("abort_next_col0", {16'h0, wlog[0]}, 32'h0001);

        // Randomized activity against the model
        do_reset();
        budget = 24 * PER * DIV + 200;
        while (got0.size() < 24 && budget > 0) begin
            if ($urandom_range(0, 23) == 0) in_v[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 23) == 0) out_v[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) in_v = in_v & 16'($urandom);
            if ($urandom_range(0, 9) == 0) out_v = out_v & 16'($urandom);
            step();
            budget--;
        end
        check("rand_count", 32'(got0.size()), 32'd24);
        flush("rand");

        // Link timing accumulated over the whole run
        check("ser_stable", 32'(ser_bad), 32'd0);
        check("sck_high_len", 32'(high_bad), 32'd0);
        check("sck_low_len", 32'(low_bad), 32'd0);
        check("col_period", 32'(gap_bad), 32'd0);
        check("bits_per_latch", 32'(bits_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/activity_matrix.md
ACTIVITY_MATRIX -- requirements
Module: activity_matrix

Interface
REQ-001 Parameter CHANNELS, 16: number of MIDI ports; each has one in-activity LED and one out-activity LED; must be a multiple of COLS.
REQ-002 Parameter COLS, 8: columns (cathode lines) of the LED matrix.
REQ-003 Parameter SR_BITS, 16: total shift-register chain length; must be >= COLS + ROWS, where ROWS = 2*CHANNELS/COLS.
REQ-004 Parameter CLKDIV, 128: clk cycles per shift tick; must be >= 2.
REQ-005 Parameter HOLD, 3: number of full scan frames an LED stays lit after activity ends; 0 disables stretching.
REQ-006 Parameter COL_ACTIVE_LOW, 0: when 1, the column one-hot is inverted before shifting.
REQ-007 clk  input  1  system clock.
REQ-008 rst  input  1  reset; one clock, synchronous, active-high.
REQ-009 in  input  CHANNELS  per-port receive activity, level-sampled every clk.
REQ-010 out  input  CHANNELS  per-port transmit activity, level-sampled every clk.
REQ-011 sck  output  1  shift clock to the 74HC595 chain, registered.
REQ-012 rck  output  1  storage (latch) clock, registered.
REQ-013 ser  output  1  serial data, registered.

Function
REQ-014 A tick strobe shall assert for one clk every CLKDIV clk cycles; all scan FSM transitions occur only on tick.
REQ-015 LED map: row 2k, column c = in[k*COLS+c]; row 2k+1, column c = out[k*COLS+c]; k = 0..CHANNELS/COLS-1.
REQ-016 Each LED shall have a hold counter of width clog2(HOLD+1); while its input is sampled high, the counter loads HOLD.
REQ-017 Hold counters shall decrement by 1, saturating at 0, once per frame end (completion of the LATCH state for column COLS-1).
REQ-018 If a load and a decrement coincide in the same clk, the load wins.
REQ-019 An LED is lit when its input is high or its hold counter is non-zero.
REQ-020 FSM states: LOAD, SHIFT_LO, SHIFT_HI, LATCH; each state lasts exactly one tick.
REQ-021 LOAD: sck=0, rck=0; advance col (wraps COLS-1 -> 0; the first LOAD after reset uses col 0).
REQ-022 LOAD: snapshot word = {zeros(SR_BITS-COLS-ROWS), lit rows ROWS-1..0 for the new col, col one-hot bit COLS-1..0}; one-hot inverted if COL_ACTIVE_LOW; bitcnt = SR_BITS-1; next state SHIFT_LO.
REQ-023 SHIFT_LO: sck=0, ser=word[bitcnt] (MSB first); next state SHIFT_HI.
REQ-024 SHIFT_HI: sck=1, ser held; if bitcnt==0, next state LATCH, else bitcnt-1 and next state SHIFT_LO.
REQ-025 LATCH: sck=0, rck=1; next state LOAD.
REQ-026 One column period shall be 2*SR_BITS+2 ticks; one frame shall be COLS column periods.
REQ-027 Input changes after LOAD shall not alter the word being shifted; they are first visible at the next LOAD.
REQ-028 ser shall never change in the same tick that sck rises.
REQ-029 Activity pulses as short as one clk shall be captured, with the LED lit at the next LOAD of its column (via hold) when HOLD >= 1.

Reset
REQ-030 While rst is high: sck=0, rck=0, ser=0, tick divider=0, FSM=LOAD, col=COLS-1 (so the first LOAD selects 0), all hold counters=0.
REQ-031 Reset asserted mid-shift shall abort the transfer immediately with no rck pulse; the scan restarts at column 0.

Verification (CHANNELS=16, COLS=8, SR_BITS=16, CLKDIV=4, HOLD=3)
REQ-032 After reset with all inputs 0 -> the first word shifted is 0x0001, rck pulses after 16 sck rises, and the column one-hot walks 0x01, 0x02 .. 0x80, then 0x01.
REQ-033 in[9] held high -> in the column-1 word, row bit 2 is set: word = 0x0402 (row bits at positions 8..11).
REQ-034 A single-clk out[0] pulse -> row 1 is set in the column-0 word for exactly 3 subsequent frames, then clears.
REQ-035 COL_ACTIVE_LOW=1, inputs 0 -> the column-0 word is 0x00FE.
REQ-036 rst asserted after 5 sck rises -> no rck pulse; outputs are 0; the next word is for column 0.
REQ-037 Timing check: each column period is 34 ticks = 136 clk; sck high/low are each 4 clk; ser is stable across every sck rise.
